// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    // Register-specifier width: 16 architectural registers, R0 hard-wired zero.
    localparam int REG_W = 4;
    localparam logic [REG_W-1:0] ZERO_REG = '0;

    // Ownership of the single main-memory port.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DFILL = 2'd1,
        IFILL = 2'd2
    } arb_state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle between the pipeline datapath (master) and the hazard controller
// (slave). Performance-counter signals exist only with HAZARD_PERF_EN.
interface pipeline_hazard_ctrl_if #(
    parameter int REG_W = 4,
    parameter int CNT_W = 16
);
    logic [REG_W-1:0] id_src1;
    logic [REG_W-1:0] id_src2;
    logic             id_uses_src1;
    logic             id_uses_src2;
    logic             id_is_store;
    logic             id_branch_taken;
    logic             ex_mem_read;
    logic [REG_W-1:0] ex_dst;
    logic             ic_miss;
    logic             dc_miss;
    logic             mem_fill_done;
    logic             pc_stall;
    logic             ifid_stall;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             exmem_stall;
    logic             memwb_bubble;
    logic             mem_grant_i;
    logic             mem_grant_d;
`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] load_use_cnt;
    logic [CNT_W-1:0] dmiss_cyc_cnt;
    logic [CNT_W-1:0] imiss_cyc_cnt;

    modport master (
        output id_src1, id_src2, id_uses_src1, id_uses_src2, id_is_store,
               id_branch_taken, ex_mem_read, ex_dst, ic_miss, dc_miss, mem_fill_done,
        input  pc_stall, ifid_stall, ifid_flush, idex_bubble, exmem_stall,
               memwb_bubble, mem_grant_i, mem_grant_d,
               load_use_cnt, dmiss_cyc_cnt, imiss_cyc_cnt
    );
    modport slave (
        input  id_src1, id_src2, id_uses_src1, id_uses_src2, id_is_store,
               id_branch_taken, ex_mem_read, ex_dst, ic_miss, dc_miss, mem_fill_done,
        output pc_stall, ifid_stall, ifid_flush, idex_bubble, exmem_stall,
               memwb_bubble, mem_grant_i, mem_grant_d,
               load_use_cnt, dmiss_cyc_cnt, imiss_cyc_cnt
    );
`else
    modport master (
        output id_src1, id_src2, id_uses_src1, id_uses_src2, id_is_store,
               id_branch_taken, ex_mem_read, ex_dst, ic_miss, dc_miss, mem_fill_done,
        input  pc_stall, ifid_stall, ifid_flush, idex_bubble, exmem_stall,
               memwb_bubble, mem_grant_i, mem_grant_d
    );
    modport slave (
        input  id_src1, id_src2, id_uses_src1, id_uses_src2, id_is_store,
               id_branch_taken, ex_mem_read, ex_dst, ic_miss, dc_miss, mem_fill_done,
        output pc_stall, ifid_stall, ifid_flush, idex_bubble, exmem_stall,
               memwb_bubble, mem_grant_i, mem_grant_d
    );
`endif
endinterface

// File: rtl/pipeline_hazard_ctrl_arbiter.sv
// Main-memory port arbiter between the I-cache and D-cache fill engines.
// D wins a simultaneous miss (older instruction); a granted fill is never
// preempted and runs until mem_fill_done.
module mem_port_arbiter
    import hazard_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       icMiss,
    input  logic       dcMiss,
    input  logic       fillDone,
    output arb_state_t state,
    output logic       grantI,
    output logic       grantD
);

    arb_state_t stateNext;

    // State register; reset returns the port to IDLE, dropping any grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic: grant on the cycle after a miss, release on fill done.
    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE: begin
                if (dcMiss) begin
                    stateNext = DFILL;
                end else if (icMiss) begin
                    stateNext = IFILL;
                end
            end
            DFILL, IFILL: begin
                if (fillDone) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    assign grantD = (state == DFILL);
    assign grantI = (state == IFILL);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the five-stage pipeline: load-use stalls,
// taken-branch flushes and cache-miss freezes, plus memory-port arbitration.
// Optional feature macro: HAZARD_PERF_EN adds saturating performance counters.
module pipeline_hazard_ctrl #(
    parameter int REG_W = hazard_pkg::REG_W,
    parameter int CNT_W = 16
) (
    input logic                  clk,
    input logic                  rst,
    pipeline_hazard_ctrl_if.slave hz
);
    import hazard_pkg::*;

    arb_state_t state;
    logic       grantI;
    logic       grantD;
    logic       loadUse;
    logic       dFreeze;
    logic       iSide;

    mem_port_arbiter uArbiter (
        .clk      (clk),
        .rst      (rst),
        .icMiss   (hz.ic_miss),
        .dcMiss   (hz.dc_miss),
        .fillDone (hz.mem_fill_done),
        .state    (state),
        .grantI   (grantI),
        .grantD   (grantD)
    );

    assign hz.mem_grant_i = grantI;
    assign hz.mem_grant_d = grantD;

    // Store data (src2 of SW) is forwarded MEM-to-MEM, so it never stalls.
    assign loadUse = hz.ex_mem_read
                   && (hz.ex_dst != REG_W'(ZERO_REG))
                   && ((hz.id_uses_src1 && (hz.ex_dst == hz.id_src1))
                    || (hz.id_uses_src2 && (hz.ex_dst == hz.id_src2) && !hz.id_is_store));

    assign dFreeze = hz.dc_miss || (state == DFILL);
    assign iSide   = hz.ic_miss || (state == IFILL);

    // Priority mux: D freeze > load-use > taken branch > I-side bubble.
    always_comb begin
        hz.pc_stall     = 1'b0;
        hz.ifid_stall   = 1'b0;
        hz.ifid_flush   = 1'b0;
        hz.idex_bubble  = 1'b0;
        hz.exmem_stall  = 1'b0;
        hz.memwb_bubble = 1'b0;
        if (dFreeze) begin
            hz.pc_stall     = 1'b1;
            hz.ifid_stall   = 1'b1;
            hz.exmem_stall  = 1'b1;
            hz.memwb_bubble = 1'b1;
        end else if (loadUse) begin
            hz.pc_stall    = 1'b1;
            hz.ifid_stall  = 1'b1;
            hz.idex_bubble = 1'b1;
        end else if (hz.id_branch_taken) begin
            // PC must load the target even while an I-fill is outstanding.
            hz.ifid_flush = 1'b1;
        end else if (iSide) begin
            hz.pc_stall   = 1'b1;
            hz.ifid_flush = 1'b1;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] loadUseCnt;
    logic [CNT_W-1:0] dMissCycCnt;
    logic [CNT_W-1:0] iMissCycCnt;

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Saturating counters; a load-use cycle counts only when it actually stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            loadUseCnt  <= '0;
            dMissCycCnt <= '0;
            iMissCycCnt <= '0;
        end else begin
            if (loadUse && !dFreeze) begin
                loadUseCnt <= satInc(loadUseCnt);
            end
            if (state == DFILL) begin
                dMissCycCnt <= satInc(dMissCycCnt);
            end
            if (state == IFILL) begin
                iMissCycCnt <= satInc(iMissCycCnt);
            end
        end
    end

    assign hz.load_use_cnt  = loadUseCnt;
    assign hz.dmiss_cyc_cnt = dMissCycCnt;
    assign hz.imiss_cyc_cnt = iMissCycCnt;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Testbench for pipeline_hazard_ctrl: directed scenarios plus random traffic,
// every cycle checked against a behavioural model of the hazard rules.
module tb_pipeline_hazard_ctrl;

    localparam int RW = 4;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.REG_W(RW), .CNT_W(CW)) hz();

    pipeline_hazard_ctrl #(.REG_W(RW), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    int nCompared   = 0;
    int nMismatched = 0;

    // Model: who currently owns the memory port ("none", "data", "instr").
    string portOwner = "none";
    int    mLoadUse  = 0;
    int    mDCyc     = 0;
    int    mICyc     = 0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, check every output, then advance the model.
    task automatic runCycle(input logic r, input logic [RW-1:0] s1, input logic [RW-1:0] s2,
                            input logic u1, input logic u2, input logic st, input logic br,
                            input logic mr, input logic [RW-1:0] dst,
                            input logic im, input logic dm, input logic fd);
        bit lu, dfz, ifz;
        bit ePc, eIfs, eFl, eIdb, eExs, eMwb;
        int sat;
        @(negedge clk);
        rst = r;
        hz.id_src1 = s1;       hz.id_src2 = s2;
        hz.id_uses_src1 = u1;  hz.id_uses_src2 = u2;
        hz.id_is_store = st;   hz.id_branch_taken = br;
        hz.ex_mem_read = mr;   hz.ex_dst = dst;
        hz.ic_miss = im;       hz.dc_miss = dm;
        hz.mem_fill_done = fd;
        #1;
        lu  = mr && (dst != 0) && ((u1 && dst == s1) || (u2 && dst == s2 && !st));
        dfz = dm || (portOwner == "data");
        ifz = im || (portOwner == "instr");
        {ePc, eIfs, eFl, eIdb, eExs, eMwb} = '0;
        if (dfz)     begin ePc = 1; eIfs = 1; eExs = 1; eMwb = 1; end
        else if (lu) begin ePc = 1; eIfs = 1; eIdb = 1; end
        else if (br) begin eFl = 1; end
        else if (ifz) begin ePc = 1; eFl = 1; end
        checkVal("pc_stall",     hz.pc_stall,     ePc);
        checkVal("ifid_stall",   hz.ifid_stall,   eIfs);
        checkVal("ifid_flush",   hz.ifid_flush,   eFl);
        checkVal("idex_bubble",  hz.idex_bubble,  eIdb);
        checkVal("exmem_stall",  hz.exmem_stall,  eExs);
        checkVal("memwb_bubble", hz.memwb_bubble, eMwb);
        checkVal("mem_grant_d",  hz.mem_grant_d,  portOwner == "data");
        checkVal("mem_grant_i",  hz.mem_grant_i,  portOwner == "instr");
`ifdef HAZARD_PERF_EN
        checkVal("load_use_cnt",  hz.load_use_cnt,  mLoadUse);
        checkVal("dmiss_cyc_cnt", hz.dmiss_cyc_cnt, mDCyc);
        checkVal("imiss_cyc_cnt", hz.imiss_cyc_cnt, mICyc);
`endif
        sat = (1 << CW) - 1;
        if (r) begin
            portOwner = "none";
            mLoadUse = 0; mDCyc = 0; mICyc = 0;
        end else begin
            if (lu && !dfz && mLoadUse < sat) mLoadUse++;
            if (portOwner == "data"  && mDCyc < sat) mDCyc++;
            if (portOwner == "instr" && mICyc < sat) mICyc++;
            if (portOwner == "none") begin
                if (dm) portOwner = "data";
                else if (im) portOwner = "instr";
            end else if (fd) begin
                portOwner = "none";
            end
        end
    endtask

    task automatic idle(input logic r);
        runCycle(r, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        // Reset, then idle inputs must give all-zero outputs.
        idle(1); idle(1);
        idle(0);
        checkVal("rst_grant_d", hz.mem_grant_d, 0);
        checkVal("rst_pc_stall", hz.pc_stall, 0);

        // Load-use on src1: one stall cycle, then the load moves to MEM.
        runCycle(0, 3, 0, 1, 0, 0, 0, 1, 3, 0, 0, 0);
        checkVal("lu_idex_bubble", hz.idex_bubble, 1);
        runCycle(0, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        checkVal("lu_next_bubble", hz.idex_bubble, 0);

        // R0 destination and store-data dependency never stall.
        runCycle(0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0);
        checkVal("lu_r0_stall", hz.pc_stall, 0);
        runCycle(0, 5, 3, 1, 1, 1, 0, 1, 3, 0, 0, 0);
        checkVal("lu_store_stall", hz.pc_stall, 0);
        // Load-use also overrides a taken branch.
        runCycle(0, 0, 6, 0, 1, 0, 1, 1, 6, 0, 0, 0);
        checkVal("lu_over_branch_flush", hz.ifid_flush, 0);

        // Simultaneous miss: D first, then I.
        runCycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        checkVal("miss_freeze", hz.memwb_bubble, 1);
        checkVal("miss_no_grant_yet", hz.mem_grant_d, 0);
        runCycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        checkVal("dfill_grant_d", hz.mem_grant_d, 1);
        runCycle(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0);
        checkVal("dfill_branch_ignored", hz.ifid_flush, 0);
        runCycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
        runCycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        checkVal("dfill_released", hz.mem_grant_d, 0);
        checkVal("ipending_flush", hz.ifid_flush, 1);
        runCycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        checkVal("ifill_grant_i", hz.mem_grant_i, 1);
        // Branch during IFILL loads the target; I-fill keeps the port.
        runCycle(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0);
        checkVal("ifill_branch_pc", hz.pc_stall, 0);
        checkVal("ifill_branch_flush", hz.ifid_flush, 1);
        // No preemption by a D miss arriving during IFILL.
        runCycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
        checkVal("ifill_no_preempt", hz.mem_grant_i, 1);
        runCycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        runCycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        checkVal("d_after_i", hz.mem_grant_d, 1);

        // Reset in the middle of a D fill.
        runCycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(0);
        checkVal("rst_mid_grant_d", hz.mem_grant_d, 0);
        checkVal("rst_mid_exmem", hz.exmem_stall, 0);
        // Fill done while IDLE is ignored.
        runCycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(0);
        checkVal("idle_done_ignored", hz.mem_grant_i, 0);

`ifdef HAZARD_PERF_EN
        // Three DFILL cycles and one load-use stall.
        idle(1);
        runCycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        runCycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        runCycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        runCycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        runCycle(0, 2, 0, 1, 0, 0, 0, 1, 2, 0, 0, 0);
        idle(0);
        checkVal("perf_dmiss", hz.dmiss_cyc_cnt, 3);
        checkVal("perf_load_use", hz.load_use_cnt, 1);
`endif

        // Random traffic with narrow register numbers to provoke matches.
        for (int i = 0; i < 800; i++) begin
            runCycle(($urandom_range(0, 63) == 0),
                     RW'($urandom_range(0, 3)), RW'($urandom_range(0, 3)),
                     1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0),
                     1'($urandom_range(0, 3) == 0), 1'($urandom),
                     RW'($urandom_range(0, 3)),
                     1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 7) == 0),
                     1'($urandom_range(0, 3) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush controller for the five-stage pipeline, in the CPU top between the decode-stage operand compare and the pipeline-register enables. Each cycle it decides load-use stalls, taken-branch flushes and cache-miss freezes. It also arbitrates the single main-memory port between the I-cache and D-cache fill engines with a registered FSM. Operand forwarding stays in the existing forwarding detectors; this block only covers cases that forwarding cannot resolve.

## Interface
Parameters:
- REG_W, 4, register-specifier width (16 architectural registers, R0 hard-wired zero)
- CNT_W, 16, width of performance counters (only with HAZARD_PERF_EN)

Ports:
- clk  in  1  pipeline clock; everything is sampled on rising edge
- rst  in  1  synchronous, active-high reset
- id_src1, id_src2  in  REG_W  source registers of the instruction in ID
- id_uses_src1, id_uses_src2  in  1  source actually read by that instruction
- id_is_store  in  1  ID instruction is SW (src2 is store data)
- id_branch_taken  in  1  branch resolved taken in ID
- ex_mem_read  in  1  instruction in EX is a load
- ex_dst  in  REG_W  destination register of the EX instruction
- ic_miss, dc_miss  in  1  level miss indications from the caches
- mem_fill_done  in  1  one-cycle pulse when the granted fill completes
- pc_stall, ifid_stall, ifid_flush, idex_bubble, exmem_stall, memwb_bubble  out  1  pipeline-register controls
- mem_grant_i, mem_grant_d  out  1  memory-port grants; registered, one-hot or zero
- load_use_cnt, dmiss_cyc_cnt, imiss_cyc_cnt  out  CNT_W  perf counters (HAZARD_PERF_EN only)

## Operation
- load_use = ex_mem_read & (ex_dst != 0) & ((id_uses_src1 & ex_dst == id_src1) | (id_uses_src2 & ex_dst == id_src2 & !id_is_store)).
  - Store-data dependency is not a stall; MEM-to-MEM forwarding covers it.
- Arbiter FSM, states IDLE, DFILL, IFILL:
  - IDLE to DFILL when dc_miss; IDLE to IFILL when ic_miss & !dc_miss. D wins on simultaneous miss because it belongs to the older instruction.
  - DFILL/IFILL to IDLE on mem_fill_done.
  - A request still pending on return to IDLE is granted the following cycle.
  - No preemption: an IFILL in progress finishes even if dc_miss rises.
  - mem_grant_d = (state == DFILL); mem_grant_i = (state == IFILL).
- Priority of pipeline controls, highest first:
  1. D-side freeze: active when dc_miss or state == DFILL. Asserts pc_stall, ifid_stall, exmem_stall, and stalls ID/EX (idex_bubble = 0). Asserts memwb_bubble. Branch and load-use are ignored.
  2. load_use: asserts pc_stall, ifid_stall, idex_bubble. id_branch_taken is ignored because the branch operands are not yet valid.
  3. id_branch_taken: asserts ifid_flush with pc_stall = 0, so PC loads the target even during IFILL. An outstanding I-fill completes and is harmless.
  4. I-side: active when ic_miss or state == IFILL. Asserts pc_stall and ifid_flush, so a bubble enters ID. The back end keeps running.
- All pipeline-control outputs are combinational from current inputs and state. Only the FSM (and the counters) are registered.

## Timing
- Reset: state = IDLE; grants = 0. All combinational controls evaluate to 0 given idle inputs. Counters = 0.
- Miss raised in cycle N gives grant in N+1. mem_fill_done in cycle M drops the grant in M+1 (state IDLE). Back-to-back D then I: I grant in M+2.
- mem_fill_done while in IDLE is ignored.
- Load-use stall lasts exactly one cycle. In the next cycle the load is in MEM and the compare no longer matches.
- rst asserted mid-fill: state returns to IDLE on that edge and the grant drops. The fill engines are reset by the same signal.

## Configuration
- HAZARD_PERF_EN defined: three CNT_W saturating counters, cleared by rst, and their output ports are present.
  - load_use_cnt increments on each stall cycle caused by load_use.
  - dmiss_cyc_cnt increments each cycle in DFILL.
  - imiss_cyc_cnt increments each cycle in IFILL.
- HAZARD_PERF_EN undefined: counters and ports are absent; all other behaviour is identical.

## Structure
- hazard_pkg: arb_state_t enum (IDLE, DFILL, IFILL), REG_W, ZERO_REG constant.
- One sub-module, mem_port_arbiter: holds the FSM and the grants. The top holds the load-use compare, the priority mux and the counters.

## Test plan
- ex_mem_read=1, ex_dst=3, id_src1=3, id_uses_src1=1: pc_stall/ifid_stall/idex_bubble=1 for one cycle, 0 the next.
- Same as above but ex_dst=0, or id_is_store=1 with the match on src2 only: no stall.
- dc_miss and ic_miss rise together in cycle 5:
  - mem_grant_d=1 in cycle 6; fill_done in cycle 9 drops it in cycle 10.
  - mem_grant_i=1 in cycle 11.
  - pipeline frozen throughout DFILL.
- IFILL active and id_branch_taken=1: ifid_flush=1, pc_stall=0 that cycle; grant held until mem_fill_done.
- rst pulsed during DFILL: next cycle state IDLE, grants 0, all controls 0.
- HAZARD_PERF_EN: 3-cycle DFILL plus 1 load-use stall gives dmiss_cyc_cnt=3, load_use_cnt=1.
